// File: rtl/vinstru_seq_pkg.sv
// Shared types and default sizing for the acquisition sequencer.
package vinstru_seq_pkg;
    localparam int SEQ_CLEAR_CYCLES = 4;
    localparam int SEQ_CNT_W        = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_DRAIN   = 3'd3,
        S_HOLDOFF = 3'd4,
        S_ABORT   = 3'd5
    } seq_state_t;
endpackage

// File: rtl/vinstru_seq_timer.sv
// Loadable 32-bit down-counter; expired while the count sits at zero.
module vinstru_seq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] value,
    output logic        expired
);
    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (load)
            r_cnt <= value;
        else if (r_cnt != 32'd0)
            r_cnt <= r_cnt - 32'd1;
    end

    assign expired = (r_cnt == 32'd0);
endmodule

// File: rtl/vinstru_sequencer.sv
// Runs n_acq back-to-back instrument captures: clear pulse, run until done,
// drain, holdoff. Status and sticky error bits feed read-only registers.
module vinstru_sequencer
    import vinstru_seq_pkg::*;
#(
    parameter int CLEAR_CYCLES = SEQ_CLEAR_CYCLES,
    parameter int CNT_W        = SEQ_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_acq,
    input  logic [31:0]      holdoff,
    input  logic [31:0]      timeout,
    input  logic             vi_done,
    output logic             vi_reset,
    output logic             vi_run,
    output logic             busy,
    output logic [CNT_W-1:0] acq_count,
    output logic             seq_done,
    output logic             timeout_err,
    output logic             aborted,
    output logic             irq
);
    // Timer is loaded with N-1 on the edge entering a phase, so the phase lasts N cycles.
    localparam logic [31:0] CLR_LOAD = 32'(CLEAR_CYCLES - 1);

    seq_state_t       r_state;
    logic [CNT_W-1:0] r_n_acq;
    logic [31:0]      r_holdoff;
    logic [31:0]      r_timeout;
    logic [CNT_W-1:0] r_acq_count;
    logic             r_vi_reset, r_vi_run, r_busy, r_irq;
    logic             r_seq_done, r_timeout_err, r_aborted;

    seq_state_t  w_next;
    logic        w_tmr_load, w_tmr_expired;
    logic [31:0] w_tmr_value;
    logic        w_accept, w_capt, w_tmo_go, w_abort_go;

    vinstru_seq_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_tmr_load),
        .value   (w_tmr_value),
        .expired (w_tmr_expired)
    );

    assign w_accept = (r_state == S_IDLE) && start;

    always_comb begin
        w_next      = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_value = CLR_LOAD;
        w_capt      = 1'b0;
        w_tmo_go    = 1'b0;
        w_abort_go  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && n_acq != '0) begin
                    w_next     = S_CLEAR;
                    w_tmr_load = 1'b1;
                end
            end
            S_CLEAR: begin
                if (w_tmr_expired) begin
                    w_next      = S_RUN;
                    w_tmr_load  = 1'b1;
                    w_tmr_value = r_timeout - 32'd1;
                end
            end
            S_RUN: begin
                if (vi_done) begin
                    w_next = S_DRAIN;
                    w_capt = 1'b1;
                end else if (r_timeout != 32'd0 && w_tmr_expired) begin
                    w_next     = S_ABORT;
                    w_tmr_load = 1'b1;
                    w_tmo_go   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!vi_done) begin
                    if (r_acq_count == r_n_acq) begin
                        w_next = S_IDLE;
                    end else if (r_holdoff == 32'd0) begin
                        w_next     = S_CLEAR;
                        w_tmr_load = 1'b1;
                    end else begin
                        w_next      = S_HOLDOFF;
                        w_tmr_load  = 1'b1;
                        w_tmr_value = r_holdoff - 32'd1;
                    end
                end
            end
            S_HOLDOFF: begin
                if (w_tmr_expired) begin
                    w_next     = S_CLEAR;
                    w_tmr_load = 1'b1;
                end
            end
            S_ABORT: begin
                if (w_tmr_expired)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // A requested abort overrides whatever this cycle would otherwise do.
        if (abort && r_state != S_IDLE && r_state != S_ABORT) begin
            w_next      = S_ABORT;
            w_tmr_load  = 1'b1;
            w_tmr_value = CLR_LOAD;
            w_capt      = 1'b0;
            w_tmo_go    = 1'b0;
            w_abort_go  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_n_acq       <= '0;
            r_holdoff     <= '0;
            r_timeout     <= '0;
            r_acq_count   <= '0;
            r_vi_reset    <= 1'b0;
            r_vi_run      <= 1'b0;
            r_busy        <= 1'b0;
            r_irq         <= 1'b0;
            r_seq_done    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_aborted     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_vi_reset <= (w_next == S_CLEAR) || (w_next == S_ABORT);
            r_vi_run   <= (w_next == S_RUN);
            r_busy     <= (w_next != S_IDLE);
            r_irq      <= ((r_state != S_IDLE) && (w_next == S_IDLE)) ||
                          (w_accept && n_acq == '0);
            if (w_accept) begin
                r_n_acq       <= n_acq;
                r_holdoff     <= holdoff;
                r_timeout     <= timeout;
                r_acq_count   <= '0;
                r_seq_done    <= (n_acq == '0);
                r_timeout_err <= 1'b0;
                r_aborted     <= 1'b0;
            end
            if (w_capt && r_acq_count != {CNT_W{1'b1}})
                r_acq_count <= r_acq_count + CNT_W'(1);
            if (r_state == S_DRAIN && w_next == S_IDLE)
                r_seq_done <= 1'b1;
            if (w_tmo_go)
                r_timeout_err <= 1'b1;
            if (w_abort_go)
                r_aborted <= 1'b1;
        end
    end

    assign vi_reset    = r_vi_reset;
    assign vi_run      = r_vi_run;
    assign busy        = r_busy;
    assign acq_count   = r_acq_count;
    assign seq_done    = r_seq_done;
    assign timeout_err = r_timeout_err;
    assign aborted     = r_aborted;
    assign irq         = r_irq;
endmodule

// File: tb/tb_vinstru_sequencer.sv
// Bench for vinstru_sequencer: phase-script reference model compared every
// cycle, a reactive instrument model, and directed scenarios with literal checks.
`timescale 1ns/1ps
module tb_vinstru_sequencer;
    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset, start, abort, vi_done;
    logic [15:0] n_acq;
    logic [31:0] holdoff, timeout;
    logic        vi_reset, vi_run, busy, seq_done, timeout_err, aborted, irq;
    logic [15:0] acq_count;

    vinstru_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .n_acq(n_acq), .holdoff(holdoff), .timeout(timeout), .vi_done(vi_done),
        .vi_reset(vi_reset), .vi_run(vi_run), .busy(busy), .acq_count(acq_count),
        .seq_done(seq_done), .timeout_err(timeout_err), .aborted(aborted), .irq(irq)
    );

    int checks = 0, failures = 0;
    int cyc = 0;
    bit chk_on = 1'b0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- instrument model ----------------
    int done_dly, done_hold;
    initial begin
        int run_cnt, drop_cnt;
        run_cnt = 0; drop_cnt = 0; vi_done = 1'b0;
        forever begin
            @(negedge clk);
            if (vi_run) begin
                if (!vi_done) begin
                    run_cnt++;
                    if (done_dly != 0 && run_cnt >= done_dly) begin vi_done = 1'b1; drop_cnt = 0; end
                end
            end else begin
                run_cnt = 0;
                if (vi_done) begin
                    drop_cnt++;
                    if (drop_cnt >= done_hold) vi_done = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic        e_reset, e_run, e_busy, e_done, e_tmo, e_abt, e_irq;
    logic [15:0] e_cnt;
    logic [15:0] m_n;
    logic [31:0] m_h, m_t;
    logic        s_start, s_abort, s_done;
    int          m_rst_cnt = 0, m_rst_ack = 0;

    always @(posedge reset) m_rst_cnt++;

    task automatic zero_exp();
        e_reset = 0; e_run = 0; e_busy = 0; e_done = 0; e_tmo = 0; e_abt = 0; e_irq = 0; e_cnt = '0;
    endtask

    // ev: 0 normal edge, 1 abort requested, 2 reset seen
    task automatic step(output int ev);
        @(posedge clk);
        s_start = start; s_abort = abort; s_done = vi_done;
        e_irq = 1'b0;
        ev = 0;
        if (reset || m_rst_cnt != m_rst_ack) begin
            m_rst_ack = m_rst_cnt; zero_exp(); ev = 2;
        end else if (s_abort) ev = 1;
    endtask

    task automatic abort_phase(input bit via_abort);
        int ev;
        e_run = 0; e_reset = 1;
        if (via_abort) e_abt = 1;
        repeat (C) begin step(ev); if (ev == 2) return; end
        e_reset = 0; e_busy = 0; e_irq = 1;
    endtask

    task automatic run_seq();
        int ev;
        logic [31:0] k;
        forever begin
            e_reset = 1;
            repeat (C) begin
                step(ev); if (ev == 2) return;
                if (ev == 1) begin abort_phase(1); return; end
            end
            e_reset = 0; e_run = 1; k = 0;
            forever begin
                step(ev); if (ev == 2) return;
                if (ev == 1) begin abort_phase(1); return; end
                k++;
                if (s_done) break;
                if (m_t != 0 && k == m_t) begin e_tmo = 1; abort_phase(0); return; end
            end
            e_run = 0;
            if (e_cnt != 16'hFFFF) e_cnt++;
            do begin
                step(ev); if (ev == 2) return;
                if (ev == 1) begin abort_phase(1); return; end
            end while (s_done);
            if (e_cnt == m_n) begin e_busy = 0; e_done = 1; e_irq = 1; return; end
            repeat (m_h) begin
                step(ev); if (ev == 2) return;
                if (ev == 1) begin abort_phase(1); return; end
            end
        end
    endtask

    initial begin
        int ev;
        zero_exp();
        forever begin
            step(ev);
            if (ev == 2 || !s_start) continue;
            m_n = n_acq; m_h = holdoff; m_t = timeout;
            e_cnt = '0; e_done = 0; e_tmo = 0; e_abt = 0;
            if (m_n == 0) begin e_done = 1; e_irq = 1; end
            else begin e_busy = 1; run_seq(); end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_on && !reset && m_rst_cnt == m_rst_ack) begin
            chk("cmp_vi_reset", vi_reset, e_reset);
            chk("cmp_vi_run", vi_run, e_run);
            chk("cmp_busy", busy, e_busy);
            chk("cmp_acq_count", acq_count, e_cnt);
            chk("cmp_seq_done", seq_done, e_done);
            chk("cmp_timeout_err", timeout_err, e_tmo);
            chk("cmp_aborted", aborted, e_abt);
            chk("cmp_irq", irq, e_irq);
        end
    end

    // ---------------- event monitor ----------------
    int mon_epoch = 0;
    int run_rises, reset_rises, irq_n, irq_cyc, first_run_rise, last_run_fall;
    int last_reset_rise, last_reset_len, busy_fall, min_gap;
    initial begin
        int seen, cur_len;
        bit p_run, p_rst, p_busy;
        seen = -1; p_run = 0; p_rst = 0; p_busy = 0; cur_len = 0;
        forever begin
            @(negedge clk);
            if (seen != mon_epoch) begin
                seen = mon_epoch;
                run_rises = 0; reset_rises = 0; irq_n = 0; irq_cyc = -1; first_run_rise = -1;
                last_run_fall = -1; last_reset_rise = -1; last_reset_len = 0; busy_fall = -1;
                min_gap = 1000000;
            end
            if (vi_run && !p_run) begin
                if (run_rises == 0) first_run_rise = cyc;
                run_rises++;
            end
            if (!vi_run && p_run) last_run_fall = cyc;
            if (vi_reset && !p_rst) begin
                reset_rises++; last_reset_rise = cyc; cur_len = 0;
                if (last_run_fall >= 0 && cyc - last_run_fall < min_gap) min_gap = cyc - last_run_fall;
            end
            if (vi_reset) cur_len++;
            if (!vi_reset && p_rst) last_reset_len = cur_len;
            if (irq) begin irq_n++; irq_cyc = cyc; end
            if (!busy && p_busy) busy_fall = cyc;
            p_run = vi_run; p_rst = vi_reset; p_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    int t0;

    // Returns at the negedge of cycle t0+1; start is accepted at the end of cycle t0.
    task automatic go(input logic [15:0] n, input logic [31:0] h, input logic [31:0] t);
        mon_epoch++;
        @(negedge clk);
        n_acq = n; holdoff = h; timeout = t; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        // Scramble the register values to show the sequence uses latched copies.
        n_acq = 16'hFFFF; holdoff = 32'd1; timeout = 32'd3;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin @(negedge clk); i++; end
        chk(nm, busy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        n_acq = '0; holdoff = '0; timeout = '0;
        done_dly = 20; done_hold = 2;
        repeat (3) @(negedge clk);
        chk("rst_vi_reset", vi_reset, 0); chk("rst_vi_run", vi_run, 0);
        chk("rst_busy", busy, 0);         chk("rst_acq_count", acq_count, 0);
        chk("rst_irq", irq, 0);           chk("rst_seq_done", seq_done, 0);
        reset = 1'b0; chk_on = 1'b1;
        repeat (2) @(negedge clk);

        // 1: three captures, holdoff 10, no timeout
        go(16'd3, 32'd10, 32'd0);
        wait_idle("t1_idle", 400);
        chk("t1_first_run", first_run_rise, t0 + 5);
        chk("t1_run_pulses", run_rises, 3);
        chk("t1_acq_count", acq_count, 3);
        chk("t1_seq_done", seq_done, 1);
        chk("t1_irq_count", irq_n, 1);
        chk("t1_gap_ge10", min_gap >= 10, 1);
        chk("t1_gap", min_gap, 12);

        // 2: zero captures
        go(16'd0, 32'd5, 32'd0);
        chk("t2_irq", irq, 1); chk("t2_seq_done", seq_done, 1); chk("t2_busy", busy, 0);
        @(negedge clk);
        chk("t2_irq_low", irq, 0);
        repeat (4) @(negedge clk);
        chk("t2_no_reset", reset_rises, 0); chk("t2_no_run", run_rises, 0);

        // 3: timeout of 50, instrument never finishes
        done_dly = 0;
        go(16'd2, 32'd0, 32'd50);
        wait_idle("t3_idle", 200);
        chk("t3_run_fall", last_run_fall, t0 + 55);
        chk("t3_abort_reset_rise", last_reset_rise, t0 + 55);
        chk("t3_abort_reset_len", last_reset_len, 4);
        chk("t3_timeout_err", timeout_err, 1);
        chk("t3_aborted", aborted, 0);
        chk("t3_acq_count", acq_count, 0);
        chk("t3_irq_cycle", irq_cyc, t0 + 59);

        // 4: abort during the second holdoff
        done_dly = 20; done_hold = 2;
        go(16'd5, 32'd10, 32'd0);
        repeat (64) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_idle("t4_idle", 100);
        chk("t4_aborted", aborted, 1);
        chk("t4_acq_count", acq_count, 2);
        chk("t4_reset_rise", last_reset_rise, t0 + 66);
        chk("t4_reset_len", last_reset_len, 4);
        chk("t4_busy_fall", busy_fall, t0 + 70);
        chk("t4_seq_done", seq_done, 0);

        // 5: done held 30 cycles in drain, holdoff 0
        done_dly = 5; done_hold = 30;
        go(16'd2, 32'd0, 32'd0);
        wait_idle("t5_idle", 300);
        chk("t5_clear_after_drain", last_reset_rise, t0 + 40);
        chk("t5_run_pulses", run_rises, 2);
        chk("t5_acq_count", acq_count, 2);
        chk("t5_busy_fall", busy_fall, t0 + 79);

        // 6: async reset mid-run, then a clean sequence
        done_dly = 0;
        go(16'd1, 32'd0, 32'd0);
        repeat (7) @(negedge clk);
        chk("t6_in_run", vi_run, 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_run", vi_run, 0); chk("t6_async_busy", busy, 0);
        chk("t6_async_irq", irq, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        done_dly = 3; done_hold = 1;
        go(16'd1, 32'd0, 32'd0);
        wait_idle("t6_idle", 100);
        chk("t6_acq_count", acq_count, 1);
        chk("t6_seq_done", seq_done, 1);
        chk("t6_irq_count", irq_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end
endmodule
